// File: rtl/hazard_stall_unit_pkg.sv
// Shared constants and state encoding for the hazard stall unit.
// Register 0 is hardwired to zero and never creates a dependency.
package hazard_stall_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_stall_unit_detect.sv
// Combinational hazard classifier: reports how many stall cycles the ID
// instruction needs (0, 1 or 2) given the EX and MEM stage occupants.
module hazard_detect
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W_P = REG_ADDR_W
) (
  input  logic [REG_ADDR_W_P-1:0] id_rs_i,
  input  logic [REG_ADDR_W_P-1:0] id_rt_i,
  input  logic                    id_uses_rs_i,
  input  logic                    id_uses_rt_i,
  input  logic                    id_is_branch_i,
  input  logic                    ex_mem_read_i,
  input  logic                    ex_reg_write_i,
  input  logic [REG_ADDR_W_P-1:0] ex_rd_i,
  input  logic                    mem_mem_read_i,
  input  logic [REG_ADDR_W_P-1:0] mem_rd_i,
  output logic [1:0]              need_o
);

  logic matchEx;
  logic matchMem;

  assign matchEx  = (ex_rd_i != REG_ADDR_W_P'(ZERO_REG)) &&
                    ((id_uses_rs_i && (ex_rd_i == id_rs_i)) ||
                     (id_uses_rt_i && (ex_rd_i == id_rt_i)));
  assign matchMem = (mem_rd_i != REG_ADDR_W_P'(ZERO_REG)) &&
                    ((id_uses_rs_i && (mem_rd_i == id_rs_i)) ||
                     (id_uses_rt_i && (mem_rd_i == id_rt_i)));

  // Branches compare in ID, so they cannot use EX forwarding; a load feeding
  // a branch has to wait for the data to come all the way out of MEM.
  always_comb begin
    need_o = 2'd0;
    if (id_is_branch_i && ex_mem_read_i && matchEx) begin
      need_o = 2'd2;
    end else if (id_is_branch_i && ex_reg_write_i && matchEx) begin
      need_o = 2'd1;
    end else if (id_is_branch_i && mem_mem_read_i && matchMem) begin
      need_o = 2'd1;
    end else if (ex_mem_read_i && matchEx) begin
      need_o = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Front-end stall controller: turns detected hazards into PC / IF/ID / ID/EX
// controls and holds multi-cycle stalls in a small RUN/STALL FSM.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W_P = REG_ADDR_W,
  parameter int CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [REG_ADDR_W_P-1:0] id_rs,
  input  logic [REG_ADDR_W_P-1:0] id_rt,
  input  logic                    id_uses_rs,
  input  logic                    id_uses_rt,
  input  logic                    id_is_branch,
  input  logic                    ex_mem_read,
  input  logic                    ex_reg_write,
  input  logic [REG_ADDR_W_P-1:0] ex_rd,
  input  logic                    mem_mem_read,
  input  logic [REG_ADDR_W_P-1:0] mem_rd,
  input  logic                    ex_busy,
  output logic                    PC_write,
  output logic                    IFID_write,
  output logic                    IDEX_write,
  output logic                    IDEX_bubble,
  output logic [CNT_W-1:0]        stall_count
);

  state_e            state_q, state_d;
  logic [1:0]        rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        need;
  logic              stall;

  hazard_detect #(.REG_ADDR_W_P(REG_ADDR_W_P)) u_detect (
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rs_i   (id_uses_rs),
    .id_uses_rt_i   (id_uses_rt),
    .id_is_branch_i (id_is_branch),
    .ex_mem_read_i  (ex_mem_read),
    .ex_reg_write_i (ex_reg_write),
    .ex_rd_i        (ex_rd),
    .mem_mem_read_i (mem_mem_read),
    .mem_rd_i       (mem_rd),
    .need_o         (need)
  );

  // Priority chain: reset, pipeline freeze, EX busy, then the hazard FSM.
  // Outputs are Mealy so a hazard seen in RUN stalls in the same cycle.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    PC_write    = 1'b0;
    IFID_write  = 1'b0;
    IDEX_write  = 1'b0;
    IDEX_bubble = 1'b0;
    if (reset) begin
      IDEX_bubble = 1'b1;
    end else if (enable && !ex_busy) begin
      if (state_q == ST_STALL) begin
        stall = 1'b1;
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end else if (need != 2'd0) begin
        stall = 1'b1;
        if (need == 2'd2) begin
          state_d = ST_STALL;
          rem_d   = 2'd1;
        end
      end
      PC_write    = !stall;
      IFID_write  = !stall;
      IDEX_write  = 1'b1;
      IDEX_bubble = stall;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Falling edge, matching the PC register this unit gates.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: inputs change just after the rising
// edge, Mealy outputs are sampled before the falling (active) edge.
module tb_hazard_stall_unit;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_branch;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        mem_mem_read;
  logic [4:0]  mem_rd;
  logic        ex_busy;
  logic        PC_write;
  logic        IFID_write;
  logic        IDEX_write;
  logic        IDEX_bubble;
  logic [15:0] stall_count;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [3:0] RUN_O   = 4'b1110;
  localparam logic [3:0] STALL_O = 4'b0011;
  localparam logic [3:0] FROZEN  = 4'b0000;
  localparam logic [3:0] RESET_O = 4'b0001;

  hazard_stall_unit dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .mem_mem_read (mem_mem_read),
    .mem_rd       (mem_rd),
    .ex_busy      (ex_busy),
    .PC_write     (PC_write),
    .IFID_write   (IFID_write),
    .IDEX_write   (IDEX_write),
    .IDEX_bubble  (IDEX_bubble),
    .stall_count  (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to the next rising edge; inputs are driven right after it.
  task automatic applyStimulus();
    @(posedge clock);
  endtask

  task automatic idleInputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_branch = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    ex_rd = 5'd0; mem_mem_read = 1'b0; mem_rd = 5'd0; ex_busy = 1'b0;
  endtask

  task automatic branchLoadUse();
    idleInputs();
    id_is_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd8;
    ex_mem_read = 1'b1; ex_rd = 5'd8;
  endtask

  task automatic loadUse();
    idleInputs();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  // Compare {PC_write, IFID_write, IDEX_write, IDEX_bubble} after settling.
  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    #1;
    observed = {PC_write, IFID_write, IDEX_write, IDEX_bubble};
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
  endtask

  task automatic checkStalls(input string tag, input logic [15:0] expected);
    checkCount++;
    assert (stall_count === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, stall_count, expected);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    idleInputs();

    // Two reset cycles
    applyStimulus(); checkOutput("reset_c1", RESET_O);
    applyStimulus(); checkOutput("reset_c2", RESET_O);
    applyStimulus(); reset = 1'b0; idleInputs();
    checkOutput("idle", RUN_O); checkStalls("idle_cnt", 16'd0);

    // Load-use: one stall
    applyStimulus(); loadUse(); checkOutput("loaduse", STALL_O);
    applyStimulus(); idleInputs(); checkOutput("loaduse_after", RUN_O);
    checkStalls("loaduse_cnt", 16'd1);

    // Register 0 never stalls
    applyStimulus(); loadUse(); ex_rd = 5'd0; id_rs = 5'd0;
    checkOutput("reg0", RUN_O);
    applyStimulus(); idleInputs(); checkStalls("reg0_cnt", 16'd1);

    // Branch on a load: two stalls even though inputs go idle after cycle 1
    applyStimulus(); branchLoadUse(); checkOutput("brload_c1", STALL_O);
    applyStimulus(); idleInputs(); checkOutput("brload_c2", STALL_O);
    applyStimulus(); checkOutput("brload_done", RUN_O);
    checkStalls("brload_cnt", 16'd3);

    // Branch on an ALU result in EX: one stall
    applyStimulus(); idleInputs();
    id_is_branch = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd3;
    ex_reg_write = 1'b1; ex_rd = 5'd3;
    checkOutput("bralu", STALL_O);
    applyStimulus(); idleInputs(); checkOutput("bralu_after", RUN_O);
    checkStalls("bralu_cnt", 16'd4);

    // Branch on a load in MEM: one stall
    applyStimulus(); idleInputs();
    id_is_branch = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd3;
    mem_mem_read = 1'b1; mem_rd = 5'd3;
    checkOutput("brmem", STALL_O);
    applyStimulus(); idleInputs(); checkOutput("brmem_after", RUN_O);
    checkStalls("brmem_cnt", 16'd5);

    // Non-branch ALU dependency is forwarded, no stall
    applyStimulus(); idleInputs();
    id_uses_rt = 1'b1; id_rt = 5'd3; ex_reg_write = 1'b1; ex_rd = 5'd3;
    checkOutput("alufwd", RUN_O);
    applyStimulus(); idleInputs(); checkStalls("alufwd_cnt", 16'd5);

    // ex_busy for 3 cycles in the middle of a two-cycle stall
    applyStimulus(); branchLoadUse(); checkOutput("busy_start", STALL_O);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(); idleInputs(); ex_busy = 1'b1;
      checkOutput("busy_frozen", FROZEN);
      checkStalls("busy_cnt", 16'd6);
    end
    applyStimulus(); idleInputs(); checkOutput("busy_resume", STALL_O);
    applyStimulus(); checkOutput("busy_done", RUN_O);
    checkStalls("busy_done_cnt", 16'd7);

    // enable low in the middle of a stall
    applyStimulus(); branchLoadUse(); checkOutput("en_start", STALL_O);
    applyStimulus(); idleInputs(); enable = 1'b0;
    checkOutput("en_frozen", FROZEN); checkStalls("en_cnt", 16'd8);
    applyStimulus(); enable = 1'b1; checkOutput("en_resume", STALL_O);
    applyStimulus(); checkOutput("en_done", RUN_O);
    checkStalls("en_done_cnt", 16'd9);

    // Reset while in STALL
    applyStimulus(); branchLoadUse(); checkOutput("rst_stall_start", STALL_O);
    applyStimulus(); idleInputs(); reset = 1'b1;
    checkOutput("rst_in_stall", RESET_O);
    applyStimulus(); reset = 1'b0; checkOutput("rst_to_run", RUN_O);
    checkStalls("rst_cnt", 16'd0);

    // Saturation: hold a load-use hazard until the counter is all ones
    applyStimulus(); loadUse(); checkOutput("sat_start", STALL_O);
    repeat (65534) @(posedge clock);
    applyStimulus(); checkStalls("sat_reach", 16'hFFFF);
    checkOutput("sat_stall", STALL_O);
    applyStimulus(); checkStalls("sat_hold", 16'hFFFF);
    idleInputs(); checkOutput("sat_idle", RUN_O);
    applyStimulus(); checkStalls("sat_final", 16'hFFFF);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
